// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the mux4 round-robin arbiter.
// The arbiter takes the slave view; requesters (or a bench) take the master view.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  sel,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output sel,
    output busy,
    output timeout
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared mux4 datapath: registered one-hot grant and mux select,
// hold-time limit with timeout pulse, and a guaranteed idle cycle between owners.
module mux4_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input logic               clk,
  input logic               rst,
  mux4_rr_arbiter_if.slave  bus
);

  localparam bit               HoldEn   = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_MAX - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           r_state, w_state_d;
  logic [3:0]       r_gnt, w_gnt_d;
  logic [1:0]       r_sel, w_sel_d;
  logic             r_busy, w_busy_d;
  logic             r_timeout, w_timeout_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [1:0]       r_ptr, w_ptr_d;

  logic [1:0]       w_win;
  logic             w_found;
  logic             w_release;

  // Scan from the highest offset down so the nearest requester past ptr wins.
  always_comb begin
    w_win   = r_ptr;
    w_found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[r_ptr + 2'(k)]) begin
        w_win   = r_ptr + 2'(k);
        w_found = 1'b1;
      end
    end
  end

  assign w_release = bus.done[r_sel] || !bus.req[r_sel];

  always_comb begin
    w_state_d   = r_state;
    w_gnt_d     = r_gnt;
    w_sel_d     = r_sel;
    w_busy_d    = r_busy;
    w_timeout_d = 1'b0;
    w_cnt_d     = r_cnt;
    w_ptr_d     = r_ptr;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_gnt_d   = 4'b0001 << w_win;
          w_sel_d   = w_win;
          w_busy_d  = 1'b1;
          w_cnt_d   = '0;
          w_ptr_d   = w_win + 2'd1;
          w_state_d = StGrant;
        end
      end
      StGrant: begin
        if (w_release) begin
          w_gnt_d   = 4'b0000;
          w_busy_d  = 1'b0;
          w_state_d = StIdle;
        end else if (HoldEn && (r_cnt == HoldLast)) begin
          w_gnt_d     = 4'b0000;
          w_busy_d    = 1'b0;
          w_timeout_d = 1'b1;
          w_state_d   = StIdle;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_gnt     <= 4'b0000;
      r_sel     <= 2'd0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_ptr     <= 2'd0;
    end else begin
      r_state   <= w_state_d;
      r_gnt     <= w_gnt_d;
      r_sel     <= w_sel_d;
      r_busy    <= w_busy_d;
      r_timeout <= w_timeout_d;
      r_cnt     <= w_cnt_d;
      r_ptr     <= w_ptr_d;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.sel     = r_sel;
  assign bus.busy    = r_busy;
  assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with a 4-cycle hold limit; expected values are hand-derived.
module tb_mux4_rr_arbiter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mux4_rr_arbiter_if u_if ();

  mux4_rr_arbiter #(
    .HOLD_MAX (4),
    .CNT_W    (3)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] gnt, input logic [1:0] sel,
                           input logic busy, input logic timeout);
    check({tag, ".gnt"}, 8'(u_if.gnt), 8'(gnt));
    check({tag, ".sel"}, 8'(u_if.sel), 8'(sel));
    check({tag, ".busy"}, 8'(u_if.busy), 8'(busy));
    check({tag, ".timeout"}, 8'(u_if.timeout), 8'(timeout));
  endtask

  // Advance one rising edge; inputs set afterwards land before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst         = 1'b1;
    u_if.req    = 4'b1111;
    u_if.done   = 4'b0000;

    // 1: reset with all requests pending, then first grant goes to 0
    tick();
    tick();
    check_out("rst_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_out("first_gnt", 4'b0001, 2'd0, 1'b1, 1'b0);
    u_if.req = 4'b0000;
    tick();
    check_out("req_drop0", 4'b0000, 2'd0, 1'b0, 1'b0);

    // 2: single requester 2, done in 4th grant cycle, foreign done ignored
    u_if.req = 4'b0100;
    tick();
    check_out("t2_c1", 4'b0100, 2'd2, 1'b1, 1'b0);
    u_if.done = 4'b0001;
    tick();
    check_out("t2_c2", 4'b0100, 2'd2, 1'b1, 1'b0);
    u_if.done = 4'b0000;
    tick();
    check_out("t2_c3", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    check_out("t2_c4", 4'b0100, 2'd2, 1'b1, 1'b0);
    u_if.done = 4'b0100;
    tick();
    check_out("t2_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
    u_if.done = 4'b0000;
    u_if.req  = 4'b0000;
    tick();
    check_out("t2_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // 3: rotate through all owners after a fresh reset
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    u_if.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      logic [1:0] o;
      o = 2'(i % 4);
      tick();
      check_out($sformatf("t3_gnt%0d", i), 4'b0001 << o, o, 1'b1, 1'b0);
      u_if.done = 4'b0001 << o;
      tick();
      check_out($sformatf("t3_idle%0d", i), 4'b0000, o, 1'b0, 1'b0);
      u_if.done = 4'b0000;
    end
    u_if.req = 4'b0000;
    tick();
    check_out("t3_quiet", 4'b0000, 2'd0, 1'b0, 1'b0);

    // 4: hold limit with a competing requester (ptr is 1 here)
    u_if.req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("t4_c%0d", i + 1), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    tick();
    check_out("t4_tmo", 4'b0000, 2'd1, 1'b0, 1'b1);
    tick();
    check_out("t4_next", 4'b1000, 2'd3, 1'b1, 1'b0);
    u_if.req = 4'b0000;
    tick();
    check_out("t4_rel", 4'b0000, 2'd3, 1'b0, 1'b0);

    // 5: lone requester 1 times out, is re-granted, then releases with done in last cycle
    u_if.req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("t5a_c%0d", i + 1), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    tick();
    check_out("t5_tmo", 4'b0000, 2'd1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("t5b_c%0d", i + 1), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    u_if.done = 4'b0010;
    tick();
    check_out("t5_done_last", 4'b0000, 2'd1, 1'b0, 1'b0);
    u_if.done = 4'b0000;
    u_if.req  = 4'b0000;
    tick();
    check_out("t5_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

    // 6: reset in the middle of owner 3's grant (ptr is 2 here)
    u_if.req = 4'b1000;
    tick();
    check_out("t6_gnt3", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick();
    rst      = 1'b1;
    u_if.req = 4'b1001;
    tick();
    check_out("t6_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_out("t6_after", 4'b0001, 2'd0, 1'b1, 1'b0);
    u_if.req = 4'b0000;
    tick();
    check_out("t6_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

    // req drop alone releases owner 2
    u_if.req = 4'b0100;
    tick();
    check_out("drop_gnt", 4'b0100, 2'd2, 1'b1, 1'b0);
    u_if.req = 4'b0000;
    tick();
    check_out("drop_rel", 4'b0000, 2'd2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
